// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 byte serializer among NREQ byte producers.
// Round-robin grant per burst. A burst ends on req_last, after MAX_BURST bytes,
// when the grantee drops valid, or when the serializer never acknowledges a start.
// Consecutive bursts are separated by an idle gap of GAP_CLKS clocks.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 16,
  parameter int GAP_CLKS  = 1250,
  parameter int ACK_CLKS  = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              grant_active,
  output logic [IDW-1:0]    grant_id,
  output logic              err_ack
);

  localparam int CNT_W    = $clog2(MAX_BURST + 1);
  localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
  localparam int ACK_LAST = (ACK_CLKS > 0) ? ACK_CLKS - 1 : 0;
  localparam int ACK_W    = (ACK_LAST > 0) ? $clog2(ACK_LAST + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t           r_state,        w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr,       w_rr_ptr_nxt;
  logic [IDW-1:0]   r_grant_id,     w_grant_id_nxt;
  logic             r_grant_active, w_grant_active_nxt;
  logic [CNT_W-1:0] r_count,        w_count_nxt;
  logic             r_last,         w_last_nxt;
  logic [7:0]       r_tx_data,      w_tx_data_nxt;
  logic             r_tx_start,     w_tx_start_nxt;
  logic             r_err_ack,      w_err_ack_nxt;
  logic [GAP_W-1:0] r_gap_cnt,      w_gap_cnt_nxt;
  logic [ACK_W-1:0] r_ack_cnt,      w_ack_cnt_nxt;

  logic [7:0]       w_data_arr [NREQ];
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_ptr_inc;
  logic [7:0]       w_sel_data;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [NREQ-1:0]  w_onehot;

  // First valid index at or after ptr, wrapping; lower offsets from ptr win.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx  = IDW'((int'(ptr) + k) % NREQ);
      pick = valid[idx] ? idx : pick;
    end
    return pick;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_split
      assign w_data_arr[gi] = req_data[8*gi+7 : 8*gi];
    end
  endgenerate

  assign w_pick      = rr_pick(req_valid, r_rr_ptr);
  assign w_sel_data  = w_data_arr[r_grant_id];
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  assign w_ptr_inc   = (r_grant_id == IDW'(NREQ - 1)) ? {IDW{1'b0}} : r_grant_id + IDW'(1);
  assign w_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;

  // Ready is the only combinational output: the grantee may hand over a byte in SEND.
  assign req_ready    = (r_state == ST_SEND) ? w_onehot : {NREQ{1'b0}};
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign grant_active = r_grant_active;
  assign grant_id     = r_grant_id;
  assign err_ack      = r_err_ack;

  // Next-state and next-output logic of the grant/serializer sequencing FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_grant_id_nxt     = r_grant_id;
    w_grant_active_nxt = r_grant_active;
    w_count_nxt        = r_count;
    w_last_nxt         = r_last;
    w_tx_data_nxt      = r_tx_data;
    w_tx_start_nxt     = 1'b0;
    w_err_ack_nxt      = r_err_ack;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_ack_cnt_nxt      = r_ack_cnt;

    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_grant_id_nxt     = w_pick;
          w_grant_active_nxt = 1'b1;
          w_count_nxt        = {CNT_W{1'b0}};
          w_state_nxt        = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (w_sel_valid) begin
          w_tx_data_nxt  = w_sel_data;
          w_last_nxt     = w_sel_last;
          w_count_nxt    = (r_count == CNT_W'(MAX_BURST)) ? r_count : r_count + CNT_W'(1);
          // A serializer still busy here counts as the ack; never start over a busy frame.
          w_tx_start_nxt = ~tx_busy;
          w_ack_cnt_nxt  = {ACK_W{1'b0}};
          w_state_nxt    = ST_WAIT_ACK;
        end else begin
          w_grant_active_nxt = 1'b0;
          w_rr_ptr_nxt       = w_ptr_inc;
          w_gap_cnt_nxt      = {GAP_W{1'b0}};
          w_state_nxt        = ST_GAP;
        end
      end

      ST_WAIT_ACK: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_ack_cnt == ACK_W'(ACK_LAST)) begin
          w_err_ack_nxt      = 1'b1;
          w_grant_active_nxt = 1'b0;
          w_rr_ptr_nxt       = w_ptr_inc;
          w_gap_cnt_nxt      = {GAP_W{1'b0}};
          w_state_nxt        = ST_GAP;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + ACK_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last || (r_count == CNT_W'(MAX_BURST))) begin
            w_grant_active_nxt = 1'b0;
            w_rr_ptr_nxt       = w_ptr_inc;
            w_gap_cnt_nxt      = {GAP_W{1'b0}};
            w_state_nxt        = ST_GAP;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_grant_active_nxt = 1'b0;
        w_state_nxt        = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset to an idle, ungranted arbiter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= {IDW{1'b0}};
      r_grant_id     <= {IDW{1'b0}};
      r_grant_active <= 1'b0;
      r_count        <= {CNT_W{1'b0}};
      r_last         <= 1'b0;
      r_tx_data      <= 8'h00;
      r_tx_start     <= 1'b0;
      r_err_ack      <= 1'b0;
      r_gap_cnt      <= {GAP_W{1'b0}};
      r_ack_cnt      <= {ACK_W{1'b0}};
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_grant_id     <= w_grant_id_nxt;
      r_grant_active <= w_grant_active_nxt;
      r_count        <= w_count_nxt;
      r_last         <= w_last_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_tx_start     <= w_tx_start_nxt;
      r_err_ack      <= w_err_ack_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_ack_cnt      <= w_ack_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a serializer model that
// stays busy for a 10-bit frame, and a monitor logging every tx_start and grant.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int MAXB  = 16;
  localparam int GAP   = 8;
  localparam int ACK   = 16;
  localparam int BIT   = 3;
  localparam int FRAME = 10 * BIT;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]  req_last = '0;
  logic [NREQ-1:0]  req_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  logic             grant_active;
  logic [IDW-1:0]   grant_id;
  logic             err_ack;

  int total = 0;
  int bad   = 0;
  bit ser_en = 1'b1;

  logic [8:0]  rq [4][$];
  logic [9:0]  log_q[$];
  int          log_cyc[$];
  logic [1:0]  rise_id[$];
  int          rise_cyc[$];
  int          fall_cyc[$];
  logic [1:0]  fall_id[$];
  int          cyc = 0;
  int          start_busy = 0;
  int          unstable = 0;
  logic        ga_prev = 1'b0;
  logic [7:0]  last_data = 8'h00;
  logic [9:0]  exp3 [8];

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .MAX_BURST(MAXB), .GAP_CLKS(GAP), .ACK_CLKS(ACK)
  ) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_active(grant_active),
    .grant_id(grant_id), .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log starts and grant edges, flag starts over busy and data changes mid-frame.
  always @(negedge clk) begin
    if (tx_start) begin
      log_q.push_back({grant_id, tx_data});
      log_cyc.push_back(cyc);
      last_data <= tx_data;
      if (tx_busy) start_busy <= start_busy + 1;
    end else if (tx_busy && grant_active && (tx_data !== last_data)) begin
      unstable <= unstable + 1;
    end
    if (grant_active && !ga_prev) begin
      rise_id.push_back(grant_id);
      rise_cyc.push_back(cyc);
    end
    if (!grant_active && ga_prev) begin
      fall_cyc.push_back(cyc);
      fall_id.push_back(grant_id);
    end
    ga_prev <= grant_active;
  end

  // Requester driver: present the head of each queue, pop on a valid&ready handshake.
  initial begin : drv
    logic [3:0] hs;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          e = rq[i][0];
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = e[7:0];
          req_last[i]         = e[8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // Serializer model: busy for FRAME clocks starting the cycle after tx_start.
  initial begin : ser
    bit st;
    int left;
    left = 0;
    forever begin
      @(negedge clk);
      st = tx_start;
      @(posedge clk);
      #1;
      if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
      if (st && ser_en) begin
        tx_busy = 1'b1;
        left    = FRAME;
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic clear_logs();
    log_q.delete(); log_cyc.delete(); rise_id.delete(); rise_cyc.delete();
    fall_cyc.delete(); fall_id.delete();
  endtask

  function automatic logic [31:0] lent(input int i);
    return (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int lcyc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100000;
  endfunction
  function automatic int rcyc(input int i);
    return (i < rise_cyc.size()) ? rise_cyc[i] : -100000;
  endfunction
  function automatic int fcyc(input int i);
    return (i < fall_cyc.size()) ? fall_cyc[i] : 100000;
  endfunction
  function automatic logic [31:0] rid(input int i);
    return (i < rise_id.size()) ? 32'(rise_id[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] fid(input int i);
    return (i < fall_id.size()) ? 32'(fall_id[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic chk_log(input string tag, input int idx, input logic [9:0] e);
    chk(tag, lent(idx), 32'(e));
  endtask

  // Wait until all queued bytes are sent and the arbiter is back in IDLE.
  task automatic settle();
    int n;
    n = 0;
    while (((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()) > 0 ||
            grant_active || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("settle_in_time", 32'(n < 3000), 32'd1);
    repeat (GAP + 3) @(negedge clk);
  endtask

  initial begin : main
    int n;
    int c_now;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_grant_id",     32'(grant_id),     32'd0);
    chk("rst_tx_start",     32'(tx_start),     32'd0);
    chk("rst_tx_data",      32'(tx_data),      32'd0);
    chk("rst_err_ack",      32'(err_ack),      32'd0);
    chk("rst_req_ready",    32'(req_ready),    32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Req0 two-byte burst, req1 waiting through the gap (rr_ptr 0 -> 2)
    clear_logs();
    push(0, 8'h55, 1'b0); push(0, 8'hA3, 1'b1); push(1, 8'hC4, 1'b1);
    settle();
    chk("t2_nbytes", 32'(log_q.size()), 32'd3);
    chk_log("t2_b0", 0, {2'd0, 8'h55});
    chk_log("t2_b1", 1, {2'd0, 8'hA3});
    chk_log("t2_b2", 2, {2'd1, 8'hC4});
    // start in WAIT_ACK, busy for FRAME clocks, 1 clk to see it drop, SEND, then start
    chk("t2_start_spacing", 32'(lcyc(1) - lcyc(0)), 32'(FRAME + 3));
    chk("t2_gid_after_burst", fid(0), 32'd0);
    chk("t2_gap_len", 32'(rcyc(1) - fcyc(0)), 32'(GAP + 1));
    chk("t2_grant1", rid(1), 32'd1);

    // All four valid with last on every byte; rr_ptr starts at 2
    clear_logs();
    for (int i = 0; i < NREQ; i++) push(i, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < NREQ; i++) push(i, 8'(8'h20 + i), 1'b1);
    exp3 = '{{2'd2, 8'h12}, {2'd3, 8'h13}, {2'd0, 8'h10}, {2'd1, 8'h11},
             {2'd2, 8'h22}, {2'd3, 8'h23}, {2'd0, 8'h20}, {2'd1, 8'h21}};
    settle();
    chk("t3_nbytes", 32'(log_q.size()), 32'd8);
    for (int j = 0; j < 8; j++) chk_log($sformatf("t3_b%0d", j), j, exp3[j]);

    // Req2 streams 20 bytes without last; req3 has one byte (rr_ptr 2)
    clear_logs();
    for (int k = 0; k < 20; k++) push(2, 8'(8'h40 + k), 1'b0);
    push(3, 8'h77, 1'b1);
    settle();
    chk("t4_nbytes", 32'(log_q.size()), 32'd21);
    for (int k = 0; k < 16; k++) chk_log($sformatf("t4_a%0d", k), k, {2'd2, 8'(8'h40 + k)});
    chk_log("t4_req3", 16, {2'd3, 8'h77});
    for (int k = 0; k < 4; k++) chk_log($sformatf("t4_b%0d", k), 17 + k, {2'd2, 8'(8'h50 + k)});
    chk("t4_grant0", rid(0), 32'd2);
    chk("t4_grant1", rid(1), 32'd3);
    chk("t4_grant2", rid(2), 32'd2);

    // Serializer never acknowledges req0's byte; req2 served next (rr_ptr 3)
    clear_logs();
    ser_en = 1'b0;
    push(0, 8'h99, 1'b1); push(2, 8'h5A, 1'b1);
    n = 0;
    while (!err_ack && n < 500) begin
      @(negedge clk);
      n++;
    end
    c_now = cyc;
    chk("t5_err_seen", 32'(err_ack), 32'd1);
    chk("t5_err_delay", 32'(c_now - lcyc(0)), 32'(ACK));
    chk("t5_grant_released", 32'(grant_active), 32'd0);
    ser_en = 1'b1;
    settle();
    chk("t5_nbytes", 32'(log_q.size()), 32'd2);
    chk_log("t5_b0", 0, {2'd0, 8'h99});
    chk_log("t5_b1", 1, {2'd2, 8'h5A});
    chk("t5_err_sticky", 32'(err_ack), 32'd1);

    // Req1 drops valid after 3 bytes (rr_ptr 3 -> 2)
    clear_logs();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b0);
    settle();
    chk("t6_nbytes", 32'(log_q.size()), 32'd3);
    chk_log("t6_b2", 2, {2'd1, 8'h63});
    chk("t6_nbursts", 32'(rise_id.size()), 32'd1);
    clear_logs();
    push(0, 8'h01, 1'b1); push(2, 8'h02, 1'b1); push(3, 8'h03, 1'b1);
    settle();
    chk_log("t6_order0", 0, {2'd2, 8'h02});
    chk_log("t6_order1", 1, {2'd3, 8'h03});
    chk_log("t6_order2", 2, {2'd0, 8'h01});

    // Reset in the middle of WAIT_DONE of req1 (rr_ptr 1 before reset)
    clear_logs();
    push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
    n = 0;
    while (!tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t1_busy_seen", 32'(tx_busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_active_before", 32'(grant_active), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t1_grant_active", 32'(grant_active), 32'd0);
    chk("t1_grant_id",     32'(grant_id),     32'd0);
    chk("t1_tx_start",     32'(tx_start),     32'd0);
    chk("t1_tx_data",      32'(tx_data),      32'd0);
    chk("t1_err_ack",      32'(err_ack),      32'd0);
    chk("t1_req_ready",    32'(req_ready),    32'd0);
    rq[1].delete();
    @(negedge clk);
    nrst = 1'b1;
    n = 0;
    while (tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t1_idle_after", 32'(grant_active), 32'd0);
    clear_logs();
    push(0, 8'h80, 1'b1); push(1, 8'h81, 1'b1);
    settle();
    chk_log("t1_ptr0_first", 0, {2'd0, 8'h80});
    chk_log("t1_ptr0_second", 1, {2'd1, 8'h81});

    chk("no_start_while_busy", 32'(start_busy), 32'd0);
    chk("tx_data_stable", 32'(unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
